// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular arbiter in front of the UART TX byte path, with a stall watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_data_valid,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [GW-1:0] g, g_nx, rr_ptr, rr_nx, sel, idx, g_inc;
  logic [WW-1:0] wd, wd_nx;
  logic [NUM_REQ-1:0] onehot;
  logic xfer, expire, timeout_nx;
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (i_req_valid[idx]) sel = idx;
    end
  end
  assign o_busy          = state == GRANT;
  assign onehot          = NUM_REQ'(1) << g;
  assign o_grant         = o_busy ? onehot : '0;
  assign o_tx_data       = o_busy ? i_req_data[{g, 3'b000} +: 8] : 8'h00;
  assign o_tx_data_valid = o_busy && i_req_valid[g];
  assign o_req_ready     = (o_busy && i_tx_ready) ? onehot : '0;
  assign xfer            = o_tx_data_valid && i_tx_ready;
  assign expire          = (TIMEOUT != 0) && o_busy && !xfer && (int'(wd) == TIMEOUT - 1);
  assign g_inc           = (g == GW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  always_comb begin
    state_nx   = state;
    g_nx       = g;
    rr_nx      = rr_ptr;
    wd_nx      = wd;
    timeout_nx = 1'b0;
    if (state == IDLE) begin
      wd_nx = '0;
      if (|i_req_valid) begin
        state_nx = GRANT;
        g_nx     = sel;
      end
    end else if ((xfer && i_req_last[g]) || expire) begin
      state_nx   = IDLE;
      rr_nx      = g_inc;
      wd_nx      = '0;
      timeout_nx = expire;
    end else begin
      wd_nx = xfer ? '0 : (&wd ? wd : wd + 1'b1);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      wd        <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      g         <= g_nx;
      rr_ptr    <= rr_nx;
      wd        <= wd_nx;
      o_timeout <= timeout_nx;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios against hand-computed per-cycle expectations.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic [31:0] req_data;
  logic [3:0] req_valid, req_last, req_ready, grant;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, busy, timeout;
  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .i_req_data(req_data), .i_req_valid(req_valid),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_tx_data(tx_data),
    .o_tx_data_valid(tx_valid), .i_tx_ready(tx_ready), .o_grant(grant),
    .o_busy(busy), .o_timeout(timeout)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, t = 0, s, nx;
  logic [8:0] mem [4][8];
  int cnt [4], pos [4];
  logic [3:0] en, acc;
  logic [3:0] lg_gnt [128], lg_rdy [128];
  logic [7:0] lg_txd [128];
  logic lg_x [128], lg_to [128];
  logic [3:0] own [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0] rr_txd [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
  logic bp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] bp_exp [6] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0};
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic load(input int k, input int n, input logic [7:0] base, input logic lst);
    for (int i = 0; i < n; i++) mem[k][i] = {lst && i == n - 1, base + 8'(i)};
    cnt[k] = n;
    pos[k] = 0;
  endtask
  task automatic drive(input logic rdy);
    tx_ready = rdy;
    for (int k = 0; k < 4; k++) begin
      req_valid[k] = en[k] && pos[k] < cnt[k];
      req_data[8*k +: 8] = req_valid[k] ? mem[k][pos[k]][7:0] : 8'h00;
      req_last[k] = req_valid[k] && mem[k][pos[k]][8];
    end
  endtask
  task automatic cyc(input logic rdy);
    drive(rdy);
    #1;
    lg_gnt[t] = grant;
    lg_txd[t] = tx_data;
    lg_x[t]   = tx_valid && tx_ready;
    lg_to[t]  = timeout;
    lg_rdy[t] = req_ready;
    acc = req_valid & req_ready;
    @(negedge clk);
    for (int k = 0; k < 4; k++) if (acc[k]) pos[k]++;
    t++;
  endtask
  task automatic do_reset();
    en = '0;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      pos[k] = 0;
    end
    drive(1'b0);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    do_reset();
    // single requester 2, three bytes
    load(2, 3, 8'hA1, 1'b1);
    en = 4'b0100;
    s = t;
    repeat (5) cyc(1'b1);
    check("single_idle_gnt", lg_gnt[s], 0);
    for (int i = 1; i <= 3; i++) begin
      check("single_gnt", lg_gnt[s+i], 4'b0100);
      check("single_txd", lg_txd[s+i], 8'hA0 + 8'(i));
      check("single_xfer", lg_x[s+i], 1);
    end
    check("single_release", lg_gnt[s+4], 0);
    // rr_ptr is 3 now: 3 beats 0, then wrap to 0
    load(0, 1, 8'hB0, 1'b1);
    load(3, 1, 8'hB3, 1'b1);
    en = 4'b1001;
    s = t;
    repeat (5) cyc(1'b1);
    check("rr3_first", lg_gnt[s+1], 4'b1000);
    check("rr3_txd", lg_txd[s+1], 8'hB3);
    check("rr3_gap", lg_gnt[s+2], 0);
    check("rr3_second", lg_gnt[s+3], 4'b0001);
    // round-robin with all requesters continuously valid
    do_reset();
    for (int k = 1; k < 4; k++) load(k, 2, {4'(k), 4'h0}, 1'b1);
    load(0, 4, 8'h00, 1'b1);
    mem[0][1][8] = 1'b1;
    en = 4'b1111;
    s = t;
    repeat (16) cyc(1'b1);
    for (int m = 0; m < 5; m++) begin
      check("rr_gnt_a", lg_gnt[s+1+3*m], own[m]);
      check("rr_gnt_b", lg_gnt[s+2+3*m], own[m]);
      check("rr_txd_a", lg_txd[s+1+3*m], rr_txd[2*m]);
      check("rr_txd_b", lg_txd[s+2+3*m], rr_txd[2*m+1]);
      check("rr_gap", lg_gnt[s+3+3*m], 0);
    end
    // backpressure on requester 1
    load(1, 2, 8'h10, 1'b1);
    en = 4'b0010;
    s = t;
    for (int i = 0; i < 6; i++) cyc(bp_rdy[i]);
    nx = 0;
    for (int i = 0; i < 6; i++) begin
      check("bp_ready", lg_rdy[s+i], bp_exp[i]);
      nx += int'(lg_x[s+i]);
    end
    check("bp_xfers", nx, 2);
    check("bp_hold_txd", lg_txd[s+2], 8'h11);
    check("bp_release", lg_gnt[s+5], 0);
    // watchdog: one byte without last, then silence
    load(0, 1, 8'h55, 1'b0);
    en = 4'b0001;
    s = t;
    repeat (11) cyc(1'b1);
    load(0, 1, 8'h60, 1'b1);
    load(1, 1, 8'h61, 1'b1);
    en = 4'b0011;
    repeat (5) cyc(1'b1);
    check("wd_xfer", lg_x[s+1], 1);
    check("wd_still_held", lg_gnt[s+9], 4'b0001);
    check("wd_idle", lg_gnt[s+10], 0);
    for (int i = 0; i < 12; i++) check("wd_pulse", lg_to[s+i], i == 10);
    check("wd_next_gnt", lg_gnt[s+12], 4'b0010);
    check("wd_next_txd", lg_txd[s+12], 8'h61);
    check("wd_then_0", lg_gnt[s+14], 4'b0001);
    // last transfer on the expiry cycle
    load(2, 2, 8'hC0, 1'b1);
    en = 4'b0100;
    s = t;
    cyc(1'b1);
    cyc(1'b1);
    repeat (7) cyc(1'b0);
    repeat (3) cyc(1'b1);
    check("col_held", lg_gnt[s+8], 4'b0100);
    check("col_xfer", lg_x[s+9], 1);
    check("col_txd", lg_txd[s+9], 8'hC1);
    check("col_release", lg_gnt[s+10], 0);
    for (int i = 0; i < 12; i++) check("col_no_to", lg_to[s+i], 0);
    // async reset during requester 3's second byte
    load(3, 3, 8'h30, 1'b1);
    en = 4'b1000;
    cyc(1'b1);
    cyc(1'b1);
    drive(1'b1);
    #1;
    check("ar_pre_gnt", grant, 4'b1000);
    check("ar_pre_txd", tx_data, 8'h31);
    #2 resetn = 1'b0;
    #1;
    check("ar_grant", grant, 0);
    check("ar_busy", busy, 0);
    check("ar_txv", tx_valid, 0);
    check("ar_txd", tx_data, 0);
    check("ar_ready", req_ready, 0);
    check("ar_timeout", timeout, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) load(k, 1, 8'hE0 + 8'(k), 1'b1);
    en = 4'b1111;
    cyc(1'b1);
    cyc(1'b1);
    check("ar_after_gnt", lg_gnt[t-1], 4'b0001);
    check("ar_after_txd", lg_txd[t-1], 8'hE0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
